// File: rtl/conv_pkg.sv
// Shared definitions for the CNN layer scheduler: memory selects, FSM states, tap offsets.
// No logic of its own; constants and pure functions only.
// Not applicable: no flow control lives here.
package conv_pkg;

  localparam int IMG_W_DEF = 64;

  // Layer-memory select encodings driven on csel
  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  // Last index of the 3x3 kernel walk and of the 2x2 pool window walk
  localparam logic [3:0] TAP_LAST  = 4'd8;
  localparam logic [3:0] POOL_LAST = 4'd3;

  typedef enum logic [2:0] {
    IDLE,
    CONV_ADDR,
    CONV_WAIT,
    CONV_WR,
    POOL_RD,
    POOL_WAIT,
    POOL_WR
  } state_t;

  // Column offset table for kernel tap k = 3*(dy+1) + (dx+1), two's complement
  function automatic logic [1:0] tap_dx(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: tap_dx = 2'b11;
      4'd1, 4'd4, 4'd7: tap_dx = 2'b00;
      default:          tap_dx = 2'b01;
    endcase
  endfunction

  // Row offset table for kernel tap k, two's complement
  function automatic logic [1:0] tap_dy(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: tap_dy = 2'b11;
      4'd3, 4'd4, 4'd5: tap_dy = 2'b00;
      default:          tap_dy = 2'b01;
    endcase
  endfunction

endpackage

// File: rtl/conv_tap_addr_gen.sv
// Maps pixel (x,y) and kernel tap k to an image-ROM address plus an out-of-image pad flag.
// Purely combinational, zero cycles.
// No flow control; the caller decides when the result is used.
module conv_tap_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int ADDR_W = 12,
  localparam int CW    = $clog2(IMG_W)
) (
  input  logic [CW-1:0]     x,
  input  logic [CW-1:0]     y,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr,
  output logic              pad
);

  logic [1:0]    dx;
  logic [1:0]    dy;
  logic [CW+1:0] xs;
  logic [CW+1:0] ys;

  assign dx = tap_dx(k);
  assign dy = tap_dy(k);

  // Two guard bits: bit CW+1 flags a -1 underflow, bit CW flags reaching IMG_W
  always_comb begin
    xs   = {2'b00, x} + {{CW{dx[1]}}, dx};
    ys   = {2'b00, y} + {{CW{dy[1]}}, dy};
    pad  = xs[CW+1] | xs[CW] | ys[CW+1] | ys[CW];
    addr = pad ? '0 : {ys[CW-1:0], xs[CW-1:0]};
  end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Sequences 3x3 zero-padded conv into layer 0, then 2x2/2 max-pool into layer 1.
// Outputs registered; tap/pool valids trail their address cycle by one (1-cycle memories).
// No backpressure: ready only starts a run from IDLE and is ignored while busy.
module conv_layer_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] iaddr,
  output logic              tap_vld,
  output logic [3:0]        tap_idx,
  output logic              tap_pad,
  output logic              tap_first,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic              pool_vld,
  output logic              pool_first,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [2:0]        csel
);

  localparam int            CW        = $clog2(IMG_W);
  localparam logic [CW-1:0] XY_ONE    = CW'(1);
  localparam logic [CW-1:0] XY_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] PXY_LAST  = CW'(IMG_W / 2 - 1);

  state_t            state;
  state_t            state_nxt;
  // x/y hold the conv pixel, and are reused as px/py during the pool phase
  logic [CW-1:0]     x;
  logic [CW-1:0]     y;
  logic [CW-1:0]     x_nxt;
  logic [CW-1:0]     y_nxt;
  // k is the kernel tap in conv and the 2x2 window element in pool
  logic [3:0]        k;
  logic [3:0]        k_nxt;

  logic [ADDR_W-1:0] gen_addr;
  logic              gen_pad;
  logic              addr_pad;
  logic [ADDR_W-1:0] pool_rd_addr;
  logic [ADDR_W-1:0] conv_wr_addr;
  logic [ADDR_W-1:0] pool_wr_addr;

  // Address is generated from the upcoming counters so it lands in the register with the state
  conv_tap_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_tap_addr_gen (
    .x    (x_nxt),
    .y    (y_nxt),
    .k    (k_nxt),
    .addr (gen_addr),
    .pad  (gen_pad)
  );

  // Window element k walks (2py,2px),(2py,2px+1),(2py+1,2px),(2py+1,2px+1)
  assign pool_rd_addr = {y_nxt[CW-2:0], k_nxt[1], x_nxt[CW-2:0], k_nxt[0]};
  assign conv_wr_addr = {y, x};
  assign pool_wr_addr = {2'b00, y[CW-2:0], x[CW-2:0]};

  // State and scan-counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      k     <= k_nxt;
    end
  end

  // Next state and counter advance; bounds are explicit compares, never wrap-around
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    k_nxt     = k;
    unique case (state)
      IDLE: begin
        if (ready) begin
          state_nxt = CONV_ADDR;
          x_nxt     = '0;
          y_nxt     = '0;
          k_nxt     = '0;
        end
      end
      CONV_ADDR: begin
        if (k == TAP_LAST) state_nxt = CONV_WAIT;
        else               k_nxt     = k + 4'd1;
      end
      CONV_WAIT: state_nxt = CONV_WR;
      CONV_WR: begin
        k_nxt     = '0;
        state_nxt = CONV_ADDR;
        if (x == XY_LAST) begin
          x_nxt = '0;
          if (y == XY_LAST) begin
            y_nxt     = '0;
            state_nxt = POOL_RD;
          end else begin
            y_nxt = y + XY_ONE;
          end
        end else begin
          x_nxt = x + XY_ONE;
        end
      end
      POOL_RD: begin
        if (k == POOL_LAST) state_nxt = POOL_WAIT;
        else                k_nxt     = k + 4'd1;
      end
      POOL_WAIT: state_nxt = POOL_WR;
      POOL_WR: begin
        k_nxt     = '0;
        state_nxt = POOL_RD;
        if (x == PXY_LAST) begin
          x_nxt = '0;
          if (y == PXY_LAST) begin
            y_nxt     = '0;
            state_nxt = IDLE;
          end else begin
            y_nxt = y + XY_ONE;
          end
        end else begin
          x_nxt = x + XY_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register: strobes/addresses from the upcoming state, valids from the current one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      iaddr      <= '0;
      addr_pad   <= 1'b0;
      tap_vld    <= 1'b0;
      tap_idx    <= '0;
      tap_pad    <= 1'b0;
      tap_first  <= 1'b0;
      crd        <= 1'b0;
      caddr_rd   <= '0;
      pool_vld   <= 1'b0;
      pool_first <= 1'b0;
      cwr        <= 1'b0;
      caddr_wr   <= '0;
      csel       <= CSEL_NONE;
    end else begin
      busy <= (state_nxt != IDLE);

      if (state_nxt == CONV_ADDR) begin
        iaddr    <= gen_addr;
        addr_pad <= gen_pad;
      end
      tap_vld   <= (state == CONV_ADDR);
      tap_idx   <= k;
      tap_pad   <= (state == CONV_ADDR) && addr_pad;
      tap_first <= (state == CONV_ADDR) && (k == 4'd0);

      crd <= (state_nxt == POOL_RD);
      if (state_nxt == POOL_RD) caddr_rd <= pool_rd_addr;
      pool_vld   <= (state == POOL_RD);
      pool_first <= (state == POOL_RD) && (k == 4'd0);

      cwr <= (state_nxt == CONV_WR) || (state_nxt == POOL_WR);
      if (state_nxt == CONV_WR)      caddr_wr <= conv_wr_addr;
      else if (state_nxt == POOL_WR) caddr_wr <= pool_wr_addr;

      case (state_nxt)
        CONV_WR, POOL_RD: csel <= CSEL_L0;
        POOL_WR:          csel <= CSEL_L1;
        default:          csel <= CSEL_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: full 64x64 run plus an 8x8 instance for restart/reset cases.
module tb_conv_layer_scheduler;

  localparam int W   = 64;
  localparam int AW  = 12;
  localparam int SW  = 8;
  localparam int SAW = 6;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  // Full-size instance
  logic          reset, ready, busy, tap_vld, tap_pad, tap_first, crd, pool_vld, pool_first, cwr;
  logic [AW-1:0] iaddr, caddr_rd, caddr_wr;
  logic [3:0]    tap_idx;
  logic [2:0]    csel;

  conv_layer_scheduler #(.IMG_W(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr),
    .tap_vld(tap_vld), .tap_idx(tap_idx), .tap_pad(tap_pad), .tap_first(tap_first),
    .crd(crd), .caddr_rd(caddr_rd), .pool_vld(pool_vld), .pool_first(pool_first),
    .cwr(cwr), .caddr_wr(caddr_wr), .csel(csel)
  );

  // Small instance for repeated runs and mid-run reset
  logic           s_reset, s_ready, s_busy, s_tap_vld, s_tap_pad, s_tap_first, s_crd;
  logic           s_pool_vld, s_pool_first, s_cwr;
  logic [SAW-1:0] s_iaddr, s_caddr_rd, s_caddr_wr;
  logic [3:0]     s_tap_idx;
  logic [2:0]     s_csel;

  conv_layer_scheduler #(.IMG_W(SW), .ADDR_W(SAW)) dut_s (
    .clk(clk), .reset(s_reset), .ready(s_ready), .busy(s_busy), .iaddr(s_iaddr),
    .tap_vld(s_tap_vld), .tap_idx(s_tap_idx), .tap_pad(s_tap_pad), .tap_first(s_tap_first),
    .crd(s_crd), .caddr_rd(s_caddr_rd), .pool_vld(s_pool_vld), .pool_first(s_pool_first),
    .cwr(s_cwr), .caddr_wr(s_caddr_wr), .csel(s_csel)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected tap addresses per pixel, -1 marks a padded tap
  typedef struct {
    int px;
    int py;
    int exp[9];
  } tap_vec_t;

  // Expected window reads and write address for one pool output
  typedef struct {
    int idx;
    int rd[4];
    int wr;
  } pool_vec_t;

  tap_vec_t  tv[3];
  pool_vec_t pv[2];

  // Monitor state for the full-size instance
  bit  mon_en = 0, mon_done = 0, busy_prev = 0;
  int  cyc = 0, busy_rise = 0, busy_cnt = 0, last_wr = 0, first_wr_ofs = -1;
  int  conv_wr_cnt = 0, pool_wr_cnt = 0, spacing_err = 0, conv_order_err = 0, pool_order_err = 0;
  int  inv_err = 0, tap_vld_cnt = 0, tap_first_cnt = 0, pool_vld_cnt = 0, pool_first_cnt = 0;
  int  rd_j = 0, prev_iaddr = 0;
  int  cap_addr[3][9];
  bit  cap_pad[3][9], cap_first[3][9], cap_seen[3][9];
  int  pr_cap[2][4];
  int  pw_cap[2];

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cyc++;
        if (busy) busy_cnt++;
        if (busy && !busy_prev) busy_rise = cyc;
        if (!busy && busy_prev) mon_done = 1;
        if (crd && cwr) inv_err++;
        if (!busy && csel != 3'b000) inv_err++;
        if (tap_vld) begin
          tap_vld_cnt++;
          if (tap_first) tap_first_cnt++;
          for (int r = 0; r < 3; r++) begin
            if (conv_wr_cnt == tv[r].py * W + tv[r].px && int'(tap_idx) < 9) begin
              cap_addr[r][tap_idx]  = prev_iaddr;
              cap_pad[r][tap_idx]   = tap_pad;
              cap_first[r][tap_idx] = tap_first;
              cap_seen[r][tap_idx]  = 1'b1;
            end
          end
        end
        if (pool_vld) pool_vld_cnt++;
        if (pool_first) pool_first_cnt++;
        if (crd) begin
          for (int r = 0; r < 2; r++)
            if (pool_wr_cnt == pv[r].idx && rd_j < 4) pr_cap[r][rd_j] = int'(caddr_rd);
          rd_j++;
        end
        if (cwr) begin
          if (csel == 3'b001) begin
            if (conv_wr_cnt == 0) first_wr_ofs = cyc - busy_rise;
            else if (cyc - last_wr != 11) spacing_err++;
            if (int'(caddr_wr) != conv_wr_cnt) conv_order_err++;
            conv_wr_cnt++;
            last_wr = cyc;
          end else if (csel == 3'b011) begin
            if (int'(caddr_wr) != pool_wr_cnt) pool_order_err++;
            for (int r = 0; r < 2; r++)
              if (pool_wr_cnt == pv[r].idx) pw_cap[r] = int'(caddr_wr);
            pool_wr_cnt++;
            rd_j = 0;
          end else begin
            inv_err++;
          end
        end
        busy_prev  = busy;
        prev_iaddr = int'(iaddr);
      end
    end
  end

  // Hash of one small-instance run, held addresses masked by their strobes
  task automatic run_small(output int len, output longint h);
    len = 0;
    h   = 0;
    while (s_busy && len < 2000) begin
      h = (h * 33) ^ longint'({s_iaddr, s_tap_vld, (s_tap_vld ? s_tap_idx : 4'd0), s_tap_pad,
                               s_tap_first, s_crd, (s_crd ? s_caddr_rd : 6'd0), s_pool_vld,
                               s_pool_first, s_cwr, (s_cwr ? s_caddr_wr : 6'd0), s_csel});
      len++;
      @(negedge clk);
    end
  endtask

  int     len1, len2;
  longint h1, h2;
  bit     hit;

  initial begin
    tv[0].px = 0;  tv[0].py = 0;  tv[0].exp = '{-1, -1, -1, -1, 0, 1, -1, 64, 65};
    tv[1].px = 63; tv[1].py = 0;  tv[1].exp = '{-1, -1, -1, 62, 63, -1, 126, 127, -1};
    tv[2].px = 63; tv[2].py = 63; tv[2].exp = '{4030, 4031, -1, 4094, 4095, -1, -1, -1, -1};
    pv[0].idx = 0;    pv[0].rd = '{0, 1, 64, 65};         pv[0].wr = 0;
    pv[1].idx = 1023; pv[1].rd = '{4030, 4031, 4094, 4095}; pv[1].wr = 1023;
    for (int r = 0; r < 2; r++) begin
      pw_cap[r] = -1;
      for (int j = 0; j < 4; j++) pr_cap[r][j] = -1;
    end

    reset = 1'b1; ready = 1'b0; s_reset = 1'b1; s_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", longint'({busy, iaddr, tap_vld, tap_idx, tap_pad, tap_first, crd,
                                     caddr_rd, pool_vld, pool_first, cwr, caddr_wr, csel}), 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("busy before ready", busy, 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("busy after ready", busy, 1);

    // ready pulses during conv and during pool must be ignored
    repeat (500) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (46000) @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 10000 && !mon_done; i++) @(negedge clk);
    #2;
    check("run completes", mon_done, 1);

    check("first conv write offset", first_wr_ofs, 10);
    check("conv write spacing errors", spacing_err, 0);
    check("conv write count", conv_wr_cnt, 4096);
    check("conv write order errors", conv_order_err, 0);
    check("pool write count", pool_wr_cnt, 1024);
    check("pool write order errors", pool_order_err, 0);
    check("strobe/csel invariant errors", inv_err, 0);
    check("busy cycles", busy_cnt, 51200);
    check("tap_vld count", tap_vld_cnt, 36864);
    check("tap_first count", tap_first_cnt, 4096);
    check("pool_vld count", pool_vld_cnt, 4096);
    check("pool_first count", pool_first_cnt, 1024);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 9; k++) begin
        check($sformatf("tap (%0d,%0d) k%0d seen", tv[r].px, tv[r].py, k), cap_seen[r][k], 1);
        check($sformatf("tap (%0d,%0d) k%0d pad", tv[r].px, tv[r].py, k), cap_pad[r][k],
              (tv[r].exp[k] < 0) ? 1 : 0);
        check($sformatf("tap (%0d,%0d) k%0d iaddr", tv[r].px, tv[r].py, k), cap_addr[r][k],
              (tv[r].exp[k] < 0) ? 0 : tv[r].exp[k]);
        check($sformatf("tap (%0d,%0d) k%0d first", tv[r].px, tv[r].py, k), cap_first[r][k],
              (k == 0) ? 1 : 0);
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++)
        check($sformatf("pool out %0d read %0d", pv[r].idx, j), pr_cap[r][j], pv[r].rd[j]);
      check($sformatf("pool out %0d write addr", pv[r].idx), pw_cap[r], pv[r].wr);
    end
    @(negedge clk);
    check("idle after run", longint'({busy, cwr, crd, csel}), 0);

    // Small instance: ready held high, back-to-back runs must match
    s_reset = 1'b0;
    @(negedge clk);
    s_ready = 1'b1;
    for (int i = 0; i < 5 && !s_busy; i++) @(negedge clk);
    check("small start", s_busy, 1);
    run_small(len1, h1);
    check("small run1 busy cycles", len1, 800);
    check("small idle gap", s_busy, 0);
    @(negedge clk);
    check("small restart on held ready", s_busy, 1);
    s_ready = 1'b0;
    run_small(len2, h2);
    check("small run2 busy cycles", len2, 800);
    check("small rerun identical", h2, h1);

    // Reset in the middle of the pool phase, then restart
    @(negedge clk);
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      if (s_cwr && s_csel == 3'b011 && s_caddr_wr == 6'd5) hit = 1'b1;
      else @(negedge clk);
    end
    check("small reached pool write 5", hit, 1);
    s_reset = 1'b1;
    #1;
    check("mid-pool reset outputs", longint'({s_busy, s_iaddr, s_tap_vld, s_tap_idx, s_tap_pad,
          s_tap_first, s_crd, s_caddr_rd, s_pool_vld, s_pool_first, s_cwr, s_caddr_wr, s_csel}), 0);
    @(negedge clk);
    s_reset = 1'b0;
    @(negedge clk);
    check("idle after reset", s_busy, 0);
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    check("restart busy", s_busy, 1);
    check("restart tap0 iaddr", s_iaddr, 0);
    repeat (5) @(negedge clk);
    check("restart tap5 iaddr", s_iaddr, 1);
    repeat (2) @(negedge clk);
    check("restart tap7 iaddr", s_iaddr, 8);
    repeat (3) @(negedge clk);
    check("restart first write", longint'({s_cwr, s_csel, s_caddr_wr}), longint'({1'b1, 3'b001, 6'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
